// File: rtl/cpu_lockstep_checker.sv
// Lockstep bus comparator: buffers reference and DUV transaction streams in
// per-side FIFOs, compares heads pairwise and records counts, first mismatch and errors.
module cpu_lockstep_checker #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 64,
    parameter logic [ADDR_W+DATA_W:0] CMP_MASK = '1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       clr,
    input  logic                       stop_on_err,
    input  logic                       strict,
    input  logic                       ref_valid,
    input  logic                       ref_rw,
    input  logic [ADDR_W-1:0]          ref_addr,
    input  logic [DATA_W-1:0]          ref_data,
    input  logic                       duv_valid,
    input  logic                       duv_rw,
    input  logic [ADDR_W-1:0]          duv_addr,
    input  logic [DATA_W-1:0]          duv_data,
    output logic [1:0]                 state_o,
    output logic [$clog2(DEPTH):0]     ref_level,
    output logic [$clog2(DEPTH):0]     duv_level,
    output logic [CNT_W-1:0]           compare_count,
    output logic [CNT_W-1:0]           mismatch_count,
    output logic                       first_mm_valid,
    output logic [ADDR_W+DATA_W:0]     first_mm_ref,
    output logic [ADDR_W+DATA_W:0]     first_mm_duv,
    output logic [CNT_W-1:0]           first_mm_idx,
    output logic                       ovf_err,
    output logic                       timeout_err,
    output logic                       lockstep_err
);
    localparam int TXN_W = ADDR_W + DATA_W + 1;
    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = AW + 1;
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, HALT = 2'b10} state_t;
    state_t state, state_next;

    logic             run, pop, mm_hit, ovf_hit, lock_hit, tmo_hit, err_any;
    logic [1:0]       vld, full, nempty, push;
    logic [TXN_W-1:0] word [2];
    logic [TXN_W-1:0] head [2];
    logic [LW-1:0]    level [2];
    logic [TW-1:0]    tmo, tmo_next;

    // Strobes are valid-only: there is no ready, a valid in RUN is always taken
    // unless that side's FIFO is full with no same-cycle pop, in which case it is dropped.
    assign run     = (state == RUN);
    assign vld     = {duv_valid, ref_valid};
    assign word[0] = {ref_rw, ref_addr, ref_data};
    assign word[1] = {duv_rw, duv_addr, duv_data};
    assign pop     = run && (&nempty);

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        logic [TXN_W-1:0] mem [DEPTH];
        logic [AW:0]      wptr, rptr;

        assign level[g]  = wptr - rptr;
        assign full[g]   = (level[g] == LW'(DEPTH));
        assign nempty[g] = (level[g] != '0);
        assign head[g]   = mem[rptr[AW-1:0]];
        assign push[g]   = run && vld[g] && (!full[g] || pop);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wptr <= '0;
                rptr <= '0;
            end else if (clr) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (push[g]) wptr <= wptr + 1'b1;
                if (pop)     rptr <= rptr + 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (push[g]) mem[wptr[AW-1:0]] <= word[g];
        end
    end

    assign ref_level = level[0];
    assign duv_level = level[1];

    assign mm_hit   = pop && (((head[0] ^ head[1]) & CMP_MASK) != '0);
    assign ovf_hit  = run && (|(vld & full)) && !pop;
    assign lock_hit = run && strict && (ref_valid != duv_valid);
    assign err_any  = mm_hit || ovf_hit || lock_hit || tmo_hit;

    // The wait counter holds at TIMEOUT so it never wraps back past the threshold.
    always_comb begin
        tmo_next = '0;
        tmo_hit  = 1'b0;
        if (run && !pop && (nempty[0] ^ nempty[1])) begin
            if (tmo != TW'(TIMEOUT)) begin
                tmo_next = tmo + 1'b1;
                tmo_hit  = (tmo == TW'(TIMEOUT - 1));
            end else begin
                tmo_next = tmo;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (en) state_next = RUN;
            RUN: begin
                if (stop_on_err && err_any) state_next = HALT;
                else if (!en)               state_next = IDLE;
            end
            HALT:    state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      state <= IDLE;
        else if (clr) state <= IDLE;
        else          state <= state_next;
    end

    assign state_o = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo            <= '0;
            compare_count  <= '0;
            mismatch_count <= '0;
            first_mm_valid <= 1'b0;
            first_mm_ref   <= '0;
            first_mm_duv   <= '0;
            first_mm_idx   <= '0;
            ovf_err        <= 1'b0;
            timeout_err    <= 1'b0;
            lockstep_err   <= 1'b0;
        end else if (clr) begin
            tmo            <= '0;
            compare_count  <= '0;
            mismatch_count <= '0;
            first_mm_valid <= 1'b0;
            first_mm_ref   <= '0;
            first_mm_duv   <= '0;
            first_mm_idx   <= '0;
            ovf_err        <= 1'b0;
            timeout_err    <= 1'b0;
            lockstep_err   <= 1'b0;
        end else begin
            tmo <= tmo_next;
            if (pop && compare_count != CNT_MAX) compare_count <= compare_count + 1'b1;
            if (mm_hit) begin
                if (mismatch_count != CNT_MAX) mismatch_count <= mismatch_count + 1'b1;
                if (!first_mm_valid) begin
                    first_mm_valid <= 1'b1;
                    first_mm_ref   <= head[0];
                    first_mm_duv   <= head[1];
                    first_mm_idx   <= compare_count;
                end
            end
            if (ovf_hit)  ovf_err      <= 1'b1;
            if (tmo_hit)  timeout_err  <= 1'b1;
            if (lock_hit) lockstep_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cpu_lockstep_checker.sv
// Self-checking bench for cpu_lockstep_checker: per-pair match/mismatch expectations
// are queued when stimulus is driven and retired whenever compare_count advances.
module tb_cpu_lockstep_checker;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 32;
    localparam int TXN_W  = ADDR_W + DATA_W + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0, clr = 1'b0, stop_on_err = 1'b0, strict = 1'b0;
    logic              ref_valid = 1'b0, ref_rw = 1'b0;
    logic [ADDR_W-1:0] ref_addr = '0;
    logic [DATA_W-1:0] ref_data = '0;
    logic              duv_valid = 1'b0, duv_rw = 1'b0;
    logic [ADDR_W-1:0] duv_addr = '0;
    logic [DATA_W-1:0] duv_data = '0;
    logic [1:0]        state_o;
    logic [$clog2(DEPTH):0] ref_level, duv_level;
    logic [CNT_W-1:0]  compare_count, mismatch_count, first_mm_idx;
    logic              first_mm_valid, ovf_err, timeout_err, lockstep_err;
    logic [TXN_W-1:0]  first_mm_ref, first_mm_duv;

    int tests_run = 0;
    int tests_failed = 0;
    logic [0:0] exp_q[$];
    logic [CNT_W-1:0] prev_cc = '0, prev_mc = '0;

    cpu_lockstep_checker #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
                           .CNT_W(CNT_W), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .stop_on_err(stop_on_err),
        .strict(strict), .ref_valid(ref_valid), .ref_rw(ref_rw), .ref_addr(ref_addr),
        .ref_data(ref_data), .duv_valid(duv_valid), .duv_rw(duv_rw), .duv_addr(duv_addr),
        .duv_data(duv_data), .state_o(state_o), .ref_level(ref_level),
        .duv_level(duv_level), .compare_count(compare_count),
        .mismatch_count(mismatch_count), .first_mm_valid(first_mm_valid),
        .first_mm_ref(first_mm_ref), .first_mm_duv(first_mm_duv),
        .first_mm_idx(first_mm_idx), .ovf_err(ovf_err), .timeout_err(timeout_err),
        .lockstep_err(lockstep_err)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // scoreboard: every compare_count step retires one queued expectation
    always @(negedge clk) begin
        if (compare_count == prev_cc + 1) begin
            check("sb_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0)
                check("pair_mm", 64'(mismatch_count - prev_mc), 64'(exp_q.pop_front()));
        end
        prev_cc = compare_count;
        prev_mc = mismatch_count;
    end

    // drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ref(input logic v, input logic rw, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d);
        ref_valid = v; ref_rw = rw; ref_addr = a; ref_data = d;
    endtask

    task automatic drive_duv(input logic v, input logic rw, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d);
        duv_valid = v; duv_rw = rw; duv_addr = a; duv_data = d;
    endtask

    task automatic start_run();
        ref_valid = 1'b0;
        duv_valid = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        exp_q.delete();
        check("clr_idle", 64'(state_o), 64'd0);
        en = 1'b1;
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"}, 64'(state_o), 64'd0);
        check({tag, "_levels"}, 64'({ref_level, duv_level}), 64'd0);
        check({tag, "_counts"}, 64'({compare_count, mismatch_count}), 64'd0);
        check({tag, "_mm"}, 64'({first_mm_valid, first_mm_ref, first_mm_duv}), 64'd0);
        check({tag, "_idx"}, 64'(first_mm_idx), 64'd0);
        check({tag, "_flags"}, 64'({ovf_err, timeout_err, lockstep_err}), 64'd0);
    endtask

    task automatic run_skew(input logic strict_v, input string tag);
        logic [DATA_W-1:0] d [10];
        for (int k = 0; k < 10; k++) d[k] = DATA_W'($urandom_range(0, 255));
        strict = strict_v;
        start_run();
        for (int t = 0; t < 15; t++) begin
            if (t < 10) begin
                drive_ref(1'b1, 1'b1, 16'h1000 + 16'(t), d[t]);
                exp_q.push_back(1'b0);
            end else begin
                ref_valid = 1'b0;
            end
            if (t >= 5) drive_duv(1'b1, 1'b1, 16'h1000 + 16'(t - 5), d[t - 5]);
            else        duv_valid = 1'b0;
            tick();
        end
        ref_valid = 1'b0;
        duv_valid = 1'b0;
        repeat (4) tick();
        check({tag, "_cmp"}, 64'(compare_count), 64'd10);
        check({tag, "_mmc"}, 64'(mismatch_count), 64'd0);
        check({tag, "_ovf_tmo"}, 64'({ovf_err, timeout_err}), 64'd0);
        check({tag, "_lockstep"}, 64'(lockstep_err), 64'(strict_v));
        check({tag, "_sb_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        // reset state
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // clean lockstep, 20 identical writes
        strict = 1'b1;
        start_run();
        check("run_entry", 64'(state_o), 64'd1);
        for (int i = 0; i < 20; i++) begin
            drive_ref(1'b1, 1'b0, 16'h0200 + 16'(i), 8'(i));
            drive_duv(1'b1, 1'b0, 16'h0200 + 16'(i), 8'(i));
            exp_q.push_back(1'b0);
            tick();
        end
        ref_valid = 1'b0;
        duv_valid = 1'b0;
        repeat (3) tick();
        check("clean_cmp", 64'(compare_count), 64'd20);
        check("clean_mmc", 64'(mismatch_count), 64'd0);
        check("clean_flags", 64'({ovf_err, timeout_err, lockstep_err, first_mm_valid}), 64'd0);
        check("clean_levels", 64'({ref_level, duv_level}), 64'd0);
        check("clean_sb_drained", 64'(exp_q.size()), 64'd0);

        // skew tolerance, then the same stream under strict lockstep
        run_skew(1'b0, "skew");
        run_skew(1'b1, "skew_strict");

        // mismatch capture with halt
        strict = 1'b1;
        stop_on_err = 1'b1;
        start_run();
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                drive_ref(1'b1, 1'b1, 16'h8000, 8'hA5);
                drive_duv(1'b1, 1'b1, 16'h8000, 8'h5A);
            end else begin
                drive_ref(1'b1, 1'b1, 16'h7000 + 16'(i), 8'(i));
                drive_duv(1'b1, 1'b1, 16'h7000 + 16'(i), 8'(i));
            end
            if (i < 3) exp_q.push_back(i == 2);
            tick();
        end
        ref_valid = 1'b0;
        duv_valid = 1'b0;
        tick();
        check("mm_state", 64'(state_o), 64'd2);
        check("mm_valid", 64'(first_mm_valid), 64'd1);
        check("mm_idx", 64'(first_mm_idx), 64'd2);
        check("mm_ref", 64'(first_mm_ref), 64'({1'b1, 16'h8000, 8'hA5}));
        check("mm_duv", 64'(first_mm_duv), 64'({1'b1, 16'h8000, 8'h5A}));
        check("mm_count", 64'(mismatch_count), 64'd1);
        check("mm_cmp", 64'(compare_count), 64'd3);
        ref_valid = 1'b1;
        duv_valid = 1'b1;
        repeat (3) tick();
        check("halt_frozen_cmp", 64'(compare_count), 64'd3);
        check("halt_frozen_lvl", 64'({ref_level, duv_level}), 64'({4'd1, 4'd1}));
        check("halt_lockstep", 64'(lockstep_err), 64'd0);
        stop_on_err = 1'b0;
        strict = 1'b0;

        // overflow: 9 ref pushes into an 8-deep FIFO
        start_run();
        for (int i = 0; i < 9; i++) begin
            drive_ref(1'b1, 1'b0, 16'h3000 + 16'(i), 8'(i));
            tick();
            if (i == 7) begin
                check("ovf_full_no_err", 64'(ovf_err), 64'd0);
                check("ovf_full_level", 64'(ref_level), 64'd8);
            end
        end
        ref_valid = 1'b0;
        check("ovf_err", 64'(ovf_err), 64'd1);
        check("ovf_level", 64'(ref_level), 64'd8);
        check("ovf_duv_level", 64'(duv_level), 64'd0);
        check("ovf_state", 64'(state_o), 64'd1);

        // timeout: one ref entry, DUV silent
        start_run();
        drive_ref(1'b1, 1'b1, 16'h4000, 8'h11);
        tick();
        ref_valid = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            tick();
            if (k == 63) check("tmo_before", 64'(timeout_err), 64'd0);
            if (k == 64) check("tmo_at", 64'(timeout_err), 64'd1);
        end
        check("tmo_state", 64'(state_o), 64'd1);

        // asynchronous reset with entries queued
        start_run();
        for (int i = 0; i < 4; i++) begin
            drive_ref(1'b1, 1'b0, 16'h5000 + 16'(i), 8'(i));
            tick();
        end
        ref_valid = 1'b0;
        check("rst_pre_level", 64'(ref_level), 64'd4);
        #2 rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();

        // clear with entries queued, then a single matching pair
        start_run();
        for (int i = 0; i < 4; i++) begin
            drive_ref(1'b1, 1'b0, 16'h6000 + 16'(i), 8'(i));
            tick();
        end
        ref_valid = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_state", 64'(state_o), 64'd0);
        check("clr_levels", 64'({ref_level, duv_level}), 64'd0);
        tick();
        drive_ref(1'b1, 1'b0, 16'h0042, 8'h42);
        drive_duv(1'b1, 1'b0, 16'h0042, 8'h42);
        exp_q.push_back(1'b0);
        tick();
        ref_valid = 1'b0;
        duv_valid = 1'b0;
        repeat (2) tick();
        check("post_clr_cmp", 64'(compare_count), 64'd1);
        check("post_clr_mmc", 64'(mismatch_count), 64'd0);
        check("post_clr_sb_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
